logic_unit: RTL



---
 rtl/logic_unit.sv | 86 ++++++++
 1 files changed

// File: rtl/logic_unit.sv
// Registered bitwise logic unit with valid/ready handshakes and an internal accumulator.
// The result register is a single-entry output stage; EMPTY/FULL tracks whether it is unconsumed.
module logic_unit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_acc,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_parity
);

   typedef enum logic {StEmpty, StFull} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] y_q;
   logic             zero_q;
   logic             parity_q;
   logic [WIDTH-1:0] ea;
   logic [WIDTH-1:0] r;
   logic             xfer;

   assign in_ready   = (state_q == StEmpty) || out_ready;
   assign xfer       = in_valid && in_ready;
   assign out_valid  = (state_q == StFull);
   assign out_y      = y_q;
   assign out_zero   = zero_q;
   assign out_parity = parity_q;

   // Clear-then-operate: a clear in the same cycle zeroes the accumulator operand.
   always_comb begin
      ea = in_a;
      if (in_acc) begin
         ea = acc_clr ? '0 : acc_q;
      end
   end

   always_comb begin
      r = '0;
      case (in_op)
         3'd0:    r = ea & in_b;
         3'd1:    r = ea | in_b;
         3'd2:    r = ~ea;
         3'd3:    r = ~(ea & in_b);
         3'd4:    r = ~(ea | in_b);
         3'd5:    r = ea ^ in_b;
         3'd6:    r = ~(ea ^ in_b);
         default: r = in_b;
      endcase
   end

   // Data registers only load on a transfer, so idle X on operands never reaches state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StEmpty;
         acc_q    <= '0;
         y_q      <= '0;
         zero_q   <= 1'b1;
         parity_q <= 1'b0;
      end else if (xfer) begin
         state_q  <= StFull;
         acc_q    <= r;
         y_q      <= r;
         zero_q   <= (r == '0);
         parity_q <= ^r;
      end else begin
         if (acc_clr) begin
            acc_q <= '0;
         end
         if ((state_q == StFull) && out_ready) begin
            state_q <= StEmpty;
         end
      end
   end

endmodule
